// File: rtl/wctrl_pkg.sv
// Shared types and constants for the wordcell access controller.
// The verify-only states exist only when WCTRL_WRITE_VERIFY_EN is defined.
package wctrl_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
`ifdef WCTRL_WRITE_VERIFY_EN
    ,
    S_VSETUP,
    S_VSTROBE,
    S_VHOLD
`endif
  } wctrl_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wordcell_phase_timer.sv
// Down-counter timing one FSM phase: load N-1 on phase entry, done when it hits zero,
// so a phase lasts exactly N cycles.
module wordcell_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/wordcell_access_ctrl.sv
// Initiator for the wordcell array: one host request at a time, sequenced SETUP/STROBE/HOLD.
// Define WCTRL_WRITE_VERIFY_EN to add a readback pass after every write.
module wordcell_access_ctrl
  import wctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  // Valid/ready: a beat moves on the rising edge where valid and ready are both high;
  // the sender keeps its payload stable while valid is high and ready is low.
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_op,
  output logic [(1<<ADDR_W)-1:0]   mem_sel,
  output logic [DATA_W-1:0]        mem_in_bus,
  input  logic [DATA_W-1:0]        mem_out_bus,
  output wctrl_state_e             dbg_state
);

  localparam int NUM_WORDS = 1 << ADDR_W;
  localparam int CNT_W     = $clog2(max_int(SETUP_CYC, STROBE_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);

  wctrl_state_e           state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   mem_op_q;
  logic [NUM_WORDS-1:0]   mem_sel_q;
  logic [DATA_W-1:0]      mem_in_bus_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
`ifdef WCTRL_WRITE_VERIFY_EN
  logic                   err_q;
`endif

  logic                   accept;
  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_done;
  logic [NUM_WORDS-1:0]   sel_dec;

  assign accept  = req_valid && req_ready_q;
  assign sel_dec = {{(NUM_WORDS-1){1'b0}}, 1'b1} << addr_q;

  // Timer is reloaded on the edge that enters each multi-cycle phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETUP_LD;
    case (state_q)
      S_IDLE:    if (accept) tmr_load = 1'b1;
      S_SETUP:   if (tmr_done) begin
                   tmr_load = 1'b1;
                   tmr_val  = STROBE_LD;
                 end
`ifdef WCTRL_WRITE_VERIFY_EN
      S_HOLD:    if (we_q == OP_WRITE) tmr_load = 1'b1;
      S_VSETUP:  if (tmr_done) begin
                   tmr_load = 1'b1;
                   tmr_val  = STROBE_LD;
                 end
`endif
      default:   ;
    endcase
  end

  wordcell_phase_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rdata_q      <= '0;
      mem_op_q     <= OP_READ;
      mem_sel_q    <= '0;
      mem_in_bus_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
`ifdef WCTRL_WRITE_VERIFY_EN
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q         <= req_we;
            addr_q       <= req_addr;
            mem_op_q     <= req_we;
            mem_in_bus_q <= req_wdata;
            rdata_q      <= '0;
            req_ready_q  <= 1'b0;
`ifdef WCTRL_WRITE_VERIFY_EN
            err_q        <= 1'b0;
`endif
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_done) begin
            mem_sel_q <= sel_dec;
            state_q   <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (tmr_done) begin
            mem_sel_q <= '0;
            if (we_q == OP_READ) rdata_q <= mem_out_bus;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
`ifdef WCTRL_WRITE_VERIFY_EN
          // Writes divert into a readback pass instead of responding.
          if (we_q == OP_WRITE) begin
            rsp_valid_q <= 1'b0;
            mem_op_q    <= OP_READ;
            state_q     <= S_VSETUP;
          end
`endif
        end
`ifdef WCTRL_WRITE_VERIFY_EN
        S_VSETUP: begin
          if (tmr_done) begin
            mem_sel_q <= sel_dec;
            state_q   <= S_VSTROBE;
          end
        end
        S_VSTROBE: begin
          if (tmr_done) begin
            mem_sel_q <= '0;
            rdata_q   <= mem_out_bus;
            state_q   <= S_VHOLD;
          end
        end
        S_VHOLD: begin
          // mem_in_bus still carries the original write data here.
          err_q       <= (rdata_q != mem_in_bus_q);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            mem_op_q     <= OP_READ;
            mem_in_bus_q <= '0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign mem_op     = mem_op_q;
  assign mem_sel    = mem_sel_q;
  assign mem_in_bus = mem_in_bus_q;
  assign dbg_state  = state_q;
`ifdef WCTRL_WRITE_VERIFY_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wordcell_access_ctrl.sv
// Bench for wordcell_access_ctrl: instance 0 at default timing, instance 1 with
// SETUP_CYC=2 / STROBE_CYC=3, each attached to a behavioural word array.
module tb_wordcell_access_ctrl;
  import wctrl_pkg::*;

`ifdef WCTRL_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic         clk;
  logic         rst        [2];
  logic         req_valid  [2];
  logic         req_ready  [2];
  logic         req_we     [2];
  logic [2:0]   req_addr   [2];
  logic [7:0]   req_wdata  [2];
  logic         rsp_valid  [2];
  logic         rsp_ready  [2];
  logic [7:0]   rsp_rdata  [2];
  logic         rsp_err    [2];
  logic         mem_op     [2];
  logic [7:0]   mem_sel    [2];
  logic [7:0]   mem_in_bus [2];
  logic [7:0]   mem_out_bus[2];
  wctrl_state_e dbg_state  [2];

  logic [7:0]   amem   [2][8];
  logic [7:0]   ref_mem[2][8];
  logic         init_done;
  logic [8:0]   exp_q[$];
  int           s_cyc[2] = '{1, 2};
  int           t_cyc[2] = '{2, 3};
  int           n_checks;
  int           n_fail;
  int           last_waits;

  wordcell_access_ctrl u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_op(mem_op[0]), .mem_sel(mem_sel[0]),
    .mem_in_bus(mem_in_bus[0]), .mem_out_bus(mem_out_bus[0]), .dbg_state(dbg_state[0])
  );

  wordcell_access_ctrl #(
    .SETUP_CYC(2), .STROBE_CYC(3)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_op(mem_op[1]), .mem_sel(mem_sel[1]),
    .mem_in_bus(mem_in_bus[1]), .mem_out_bus(mem_out_bus[1]), .dbg_state(dbg_state[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int g, input int a);
    return 8'((64 + a * 7 + g * 3) % 256);
  endfunction

  // Word array: latches in_bus on a selected write strobe; bit 0 of word 5 is
  // faulty in the verify build. Unselected reads return a junk pattern.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int a = 0; a < 8; a++) begin
        if (!init_done) amem[g][a] <= init_val(g, a);
        else if (mem_sel[g][a] && mem_op[g])
          amem[g][a] <= (VERIFY && a == 5) ? (mem_in_bus[g] ^ 8'h01) : mem_in_bus[g];
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      mem_out_bus[g] = 8'hEE;
      for (int a = 0; a < 8; a++)
        if (mem_sel[g][a]) mem_out_bus[g] = amem[g][a];
    end
  end

  // Driver: one request on instance k, timeline checks, response handshake.
  // Called and returns at a falling edge.
  task automatic do_txn(input int k, input logic we, input logic [2:0] addr,
                        input logic [7:0] wdata, input int hold, input bit chain,
                        input logic cwe, input logic [2:0] caddr, input logic [7:0] cwdata);
    int s, t, p, lat, waits;
    logic [7:0] stored, onehot, exp_sel;
    logic [8:0] exp;
    logic exp_op;
    s = s_cyc[k];
    t = t_cyc[k];
    p = s + t + 1;
    lat = (we && VERIFY) ? 2 * p : p;
    if (we) begin
      stored = (VERIFY && addr == 3'd5) ? (wdata ^ 8'h01) : wdata;
      ref_mem[k][addr] = stored;
      exp_q.push_back(VERIFY ? {stored != wdata, stored} : 9'h000);
    end else begin
      exp_q.push_back({1'b0, ref_mem[k][addr]});
    end
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    waits = 0;
    while (req_ready[k] !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    last_waits = waits;
    n_checks++;
    if (waits >= 50) begin
      n_fail++;
      $display("FAIL accept_timeout k=%0d got req_ready=%b exp 1 within 50 cycles", k, req_ready[k]);
      req_valid[k] = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(negedge clk);
    if (chain) begin
      req_we[k]    = cwe;
      req_addr[k]  = caddr;
      req_wdata[k] = cwdata;
    end else begin
      req_valid[k] = 1'b0;
    end
    onehot = 8'd1 << addr;
    for (int n = 0; n <= lat; n++) begin
      if (n > 0) @(negedge clk);
      exp_sel = ((n >= s && n < s + t) || (we && VERIFY && n >= p + s && n < p + s + t)) ? onehot : 8'h00;
      exp_op = we && !(VERIFY && n >= p);
      n_checks++;
      if (mem_sel[k] !== exp_sel) begin
        n_fail++;
        $display("FAIL mem_sel k=%0d n=%0d got=%b exp=%b", k, n, mem_sel[k], exp_sel);
      end
      n_checks++;
      if (mem_op[k] !== exp_op) begin
        n_fail++;
        $display("FAIL mem_op k=%0d n=%0d got=%b exp=%b", k, n, mem_op[k], exp_op);
      end
      if (we) begin
        n_checks++;
        if (mem_in_bus[k] !== wdata) begin
          n_fail++;
          $display("FAIL mem_in_bus k=%0d n=%0d got=%h exp=%h", k, n, mem_in_bus[k], wdata);
        end
      end
      n_checks++;
      if (rsp_valid[k] !== (n == lat)) begin
        n_fail++;
        $display("FAIL rsp_valid_latency k=%0d n=%0d got=%b exp=%b", k, n, rsp_valid[k], n == lat);
      end
      n_checks++;
      if (req_ready[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL req_ready_busy k=%0d n=%0d got=%b exp=0", k, n, req_ready[k]);
      end
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({rsp_err[k], rsp_rdata[k]} !== exp) begin
      n_fail++;
      $display("FAIL rsp_data k=%0d addr=%0d we=%b got err=%b rdata=%h exp err=%b rdata=%h",
               k, addr, we, rsp_err[k], rsp_rdata[k], exp[8], exp[7:0]);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid[k] !== 1'b1 || {rsp_err[k], rsp_rdata[k]} !== exp || req_ready[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_stall k=%0d h=%0d got v=%b r=%b d=%h exp v=1 r=0 d=%h",
                 k, h, rsp_valid[k], req_ready[k], rsp_rdata[k], exp[7:0]);
      end
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    n_checks++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || mem_op[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_transfer k=%0d got v=%b r=%b op=%b exp v=0 r=1 op=0",
               k, rsp_valid[k], req_ready[k], mem_op[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
      for (int a = 0; a < 8; a++) ref_mem[k][a] = init_val(k, a);
    end
    init_done = 1'b0;
    repeat (3) @(negedge clk);
    init_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (mem_sel[k] !== 8'h00 || mem_op[k] !== 1'b0 || mem_in_bus[k] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mem k=%0d got sel=%b op=%b in=%h exp 0/0/0", k, mem_sel[k], mem_op[k], mem_in_bus[k]);
      end
      n_checks++;
      if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 8'h00 || rsp_err[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rsp k=%0d got v=%b d=%h e=%b exp 0/00/0", k, rsp_valid[k], rsp_rdata[k], rsp_err[k]);
      end
      rst[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (req_ready[k] !== 1'b1 || dbg_state[k] !== S_IDLE) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got ready=%b state=%0d exp ready=1 idle", k, req_ready[k], dbg_state[k]);
      end
    end
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 3'd3, 8'hA5, 0, 1'b0, 1'b0, 3'd0, 8'h00);
    do_txn(0, 1'b0, 3'd3, 8'h00, 0, 1'b0, 1'b0, 3'd0, 8'h00);
    do_txn(0, 1'b1, 3'd5, 8'h5A, 1, 1'b0, 1'b0, 3'd0, 8'h00);
    do_txn(0, 1'b0, 3'd5, 8'h00, 0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_back_to_back();
    do_txn(0, 1'b1, 3'd1, 8'h3C, 3, 1'b1, 1'b0, 3'd1, 8'hFF);
    do_txn(0, 1'b0, 3'd1, 8'hFF, 0, 1'b0, 1'b0, 3'd0, 8'h00);
    n_checks++;
    if (last_waits != 0) begin
      n_fail++;
      $display("FAIL back_to_back_accept got waits=%0d exp 0", last_waits);
    end
  endtask

  task automatic test_reset_in_strobe();
    int waits;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 3'd2; req_wdata[0] = 8'h77;
    waits = 0;
    while (req_ready[0] !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (s_cyc[0]) @(negedge clk);
    n_checks++;
    if (mem_sel[0] !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL strobe_before_reset got=%b exp=00000100", mem_sel[0]);
    end
    rst[0] = 1'b1;
    #1;
    n_checks++;
    if (mem_sel[0] !== 8'h00 || mem_op[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_strobe got sel=%b op=%b v=%b exp 0/0/0", mem_sel[0], mem_op[0], rsp_valid[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid[0] !== 1'b0 || mem_sel[0] !== 8'h00 || req_ready[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL no_rsp_after_reset i=%0d got v=%b sel=%b r=%b exp 0/0/1", i, rsp_valid[0], mem_sel[0], req_ready[0]);
      end
    end
    do_txn(0, 1'b0, 3'd2, 8'h00, 0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 8; a++)
      do_txn(1, 1'b1, 3'(a), 8'($urandom_range(0, 255)), 0, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int a = 0; a < 8; a++)
      do_txn(1, 1'b0, 3'(a), 8'h00, $urandom_range(0, 2), 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_txn(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
             $urandom_range(0, 3), 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    last_waits = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_in_strobe();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
